// File: rtl/yangmips_rst_seq.sv
// Reset sequencer and run supervisor: holds reset, releases domains in staggered
// order, counts run cycles and forces a supervised stop on timeout or halt.
module yangmips_rst_seq #(
    parameter int unsigned NUM_DOMAINS    = 2,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned RUN_LIMIT      = 200,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_rst_req,
    input  logic                   halt_req,
    output logic [NUM_DOMAINS-1:0] cpu_rst_o,
    output logic                   all_released,
    output logic [CNT_W-1:0]       run_cnt,
    output logic                   timeout,
    output logic                   halted
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LIMIT - 1);
    localparam logic [CNT_W-1:0] RUN_MAX    = CNT_W'(RUN_LIMIT);
    localparam bit               TIMEOUT_EN = (RUN_LIMIT != 0);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [NUM_DOMAINS-1:0] cpu_rst_nxt;
    logic                   all_released_nxt;
    logic [CNT_W-1:0]       run_cnt_nxt;
    logic [CNT_W-1:0]       run_cnt_inc;
    logic                   timeout_nxt;
    logic                   halted_nxt;
    logic [NUM_DOMAINS-1:0] rel_hit;

    // Domain i is due for release when the phase counter reaches i*STAGGER_CYCLES
    for (genvar g = 0; g < int'(NUM_DOMAINS); g++) begin : g_rel_hit
        assign rel_hit[g] = (cnt == CNT_W'(g * STAGGER_CYCLES));
    end

    // Saturating increment keeps run_cnt from wrapping when the timeout is disabled
    assign run_cnt_inc = (run_cnt == {CNT_W{1'b1}}) ? run_cnt : run_cnt + CNT_W'(1);

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        cpu_rst_nxt      = cpu_rst_o;
        all_released_nxt = all_released;
        run_cnt_nxt      = run_cnt;
        timeout_nxt      = timeout;
        halted_nxt       = halted;

        if (sw_rst_req) begin
            state_nxt        = S_HOLD;
            cnt_nxt          = '0;
            cpu_rst_nxt      = '1;
            all_released_nxt = 1'b0;
            run_cnt_nxt      = '0;
            timeout_nxt      = 1'b0;
            halted_nxt       = 1'b0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    cpu_rst_nxt = cpu_rst_o & ~rel_hit;
                    if (cnt == REL_LAST) begin
                        state_nxt        = S_RUN;
                        all_released_nxt = 1'b1;
                        cnt_nxt          = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Halt outranks a coincident timeout
                    if (halt_req) begin
                        state_nxt        = S_STOP;
                        run_cnt_nxt      = run_cnt_inc;
                        cpu_rst_nxt      = '1;
                        all_released_nxt = 1'b0;
                        halted_nxt       = 1'b1;
                    end else if (TIMEOUT_EN && (run_cnt == RUN_LAST)) begin
                        state_nxt        = S_STOP;
                        run_cnt_nxt      = RUN_MAX;
                        timeout_nxt      = 1'b1;
                        cpu_rst_nxt      = '1;
                        all_released_nxt = 1'b0;
                        halted_nxt       = 1'b1;
                    end else begin
                        run_cnt_nxt = run_cnt_inc;
                    end
                end
                S_STOP: begin
                end
                default: begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_HOLD;
            cnt          <= '0;
            cpu_rst_o    <= '1;
            all_released <= 1'b0;
            run_cnt      <= '0;
            timeout      <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cpu_rst_o    <= cpu_rst_nxt;
            all_released <= all_released_nxt;
            run_cnt      <= run_cnt_nxt;
            timeout      <= timeout_nxt;
            halted       <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_yangmips_rst_seq.sv
// Bench for yangmips_rst_seq: four configurations checked every cycle against a
// timeline model (edges since last reset), plus directed scenarios.
module tb_yangmips_rst_seq;

    localparam int unsigned CFG_N [4] = '{2, 4, 3, 2};
    localparam int unsigned CFG_H [4] = '{10, 5, 3, 2};
    localparam int unsigned CFG_S [4] = '{2, 3, 0, 1};
    localparam int unsigned CFG_R [4] = '{200, 30, 25, 0};
    localparam int unsigned CFG_W [4] = '{16, 16, 16, 4};

    logic       clk;
    logic [3:0] rst_v, sw_v, halt_v;
    logic [3:0] ar_v, to_v, hl_v;
    logic [1:0] cpu0, cpu3;
    logic [3:0] cpu1;
    logic [2:0] cpu2;
    logic [15:0] rc0, rc1, rc2;
    logic [3:0]  rc3;
    logic [3:0]  cpu_a [4];
    logic [15:0] rc_a  [4];

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    longint e_m   [4];
    bit     stop_m[4];
    longint rcs_m [4];
    bit     to_m  [4];

    yangmips_rst_seq u0 (
        .clk(clk), .rst(rst_v[0]), .sw_rst_req(sw_v[0]), .halt_req(halt_v[0]),
        .cpu_rst_o(cpu0), .all_released(ar_v[0]), .run_cnt(rc0), .timeout(to_v[0]), .halted(hl_v[0]));
    yangmips_rst_seq #(.NUM_DOMAINS(4), .HOLD_CYCLES(5), .STAGGER_CYCLES(3), .RUN_LIMIT(30), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst_v[1]), .sw_rst_req(sw_v[1]), .halt_req(halt_v[1]),
        .cpu_rst_o(cpu1), .all_released(ar_v[1]), .run_cnt(rc1), .timeout(to_v[1]), .halted(hl_v[1]));
    yangmips_rst_seq #(.NUM_DOMAINS(3), .HOLD_CYCLES(3), .STAGGER_CYCLES(0), .RUN_LIMIT(25), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst_v[2]), .sw_rst_req(sw_v[2]), .halt_req(halt_v[2]),
        .cpu_rst_o(cpu2), .all_released(ar_v[2]), .run_cnt(rc2), .timeout(to_v[2]), .halted(hl_v[2]));
    yangmips_rst_seq #(.NUM_DOMAINS(2), .HOLD_CYCLES(2), .STAGGER_CYCLES(1), .RUN_LIMIT(0), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst_v[3]), .sw_rst_req(sw_v[3]), .halt_req(halt_v[3]),
        .cpu_rst_o(cpu3), .all_released(ar_v[3]), .run_cnt(rc3), .timeout(to_v[3]), .halted(hl_v[3]));

    assign cpu_a[0] = {2'b00, cpu0};
    assign cpu_a[1] = cpu1;
    assign cpu_a[2] = {1'b0, cpu2};
    assign cpu_a[3] = {2'b00, cpu3};
    assign rc_a[0]  = rc0;
    assign rc_a[1]  = rc1;
    assign rc_a[2]  = rc2;
    assign rc_a[3]  = {12'd0, rc3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge at which the last domain clears; RUN begins here with run_cnt 0
    function automatic longint t_rel(input int k);
        return longint'(CFG_H[k]) + 1 + longint'(CFG_N[k] - 1) * longint'(CFG_S[k]);
    endfunction

    function automatic longint r_max(input int k);
        return (longint'(1) << CFG_W[k]) - 1;
    endfunction

    function automatic longint rc_of(input int k);
        longint v;
        v = e_m[k] - t_rel(k);
        return (v > r_max(k)) ? r_max(k) : v;
    endfunction

    // Model: count edges since the last reset event; a stop freezes the outputs
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_v[k] || sw_v[k]) begin
                e_m[k] = 0; stop_m[k] = 0; rcs_m[k] = 0; to_m[k] = 0;
            end else if (!stop_m[k]) begin
                if (e_m[k] >= t_rel(k)) begin
                    if (halt_v[k]) begin
                        stop_m[k] = 1;
                        rcs_m[k]  = (rc_of(k) + 1 > r_max(k)) ? r_max(k) : rc_of(k) + 1;
                        to_m[k]   = 0;
                    end else if (CFG_R[k] != 0 && rc_of(k) == longint'(CFG_R[k]) - 1) begin
                        stop_m[k] = 1;
                        rcs_m[k]  = longint'(CFG_R[k]);
                        to_m[k]   = 1;
                    end
                end
                e_m[k] = e_m[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] ecpu;
                bit ear, eto, ehl;
                longint erc;
                ecpu = 4'd0;
                if (stop_m[k]) begin
                    for (int i = 0; i < int'(CFG_N[k]); i++) ecpu = ecpu | (4'd1 << i);
                    ear = 0; eto = to_m[k]; ehl = 1; erc = rcs_m[k];
                end else begin
                    for (int i = 0; i < int'(CFG_N[k]); i++)
                        if (e_m[k] < longint'(CFG_H[k]) + 1 + longint'(i) * longint'(CFG_S[k]))
                            ecpu = ecpu | (4'd1 << i);
                    ear = (e_m[k] >= t_rel(k));
                    erc = ear ? rc_of(k) : 0;
                    eto = 0; ehl = 0;
                end
                n_cmp++;
                if (cpu_a[k] != ecpu || ar_v[k] != ear || rc_a[k] != 16'(erc) ||
                    to_v[k] != eto || hl_v[k] != ehl) begin
                    n_bad++;
                    $display("FAIL cycle_u%0d t=%0t actual/required: cpu_rst=%b/%b rel=%b/%b run_cnt=%0d/%0d timeout=%b/%b halted=%b/%b",
                             k, $time, cpu_a[k], ecpu, ar_v[k], ear, rc_a[k], erc, to_v[k], eto, hl_v[k], ehl);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_rc0(input int target, input int bound);
        bit hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            if (rc_a[0] == 16'(target)) hit = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL wait_run_cnt: got %0d expected %0d within %0d cycles", rc_a[0], target, bound);
        end
    endtask

    task automatic wait_halt0(input int bound);
        bit hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            if (hl_v[0]) hit = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL wait_halted: got 0 expected 1 within %0d cycles", bound);
        end
    endtask

    task automatic pulse_rst(input int k);
        rst_v[k] = 1'b0;
        @(negedge clk);
        rst_v[k] = 1'b1;
    endtask

    task automatic pulse_sw0();
        sw_v[0] = 1'b1;
        @(negedge clk);
        sw_v[0] = 1'b0;
    endtask

    initial begin
        rst_v = 4'h0; sw_v = 4'h0; halt_v = 4'h0;
        repeat (3) @(negedge clk);
        armed = 1;
        rst_v = 4'hF;
        chk("reset_cpu_rst", cpu_a[0], 3);
        chk("reset_run_cnt", rc_a[0], 0);

        // Release timing with defaults
        repeat (10) @(negedge clk);
        chk("edge10_cpu_rst", cpu_a[0], 3);
        @(negedge clk);
        chk("edge11_cpu_rst", cpu_a[0], 2);
        chk("edge11_released", ar_v[0], 0);
        repeat (2) @(negedge clk);
        chk("edge13_cpu_rst", cpu_a[0], 0);
        chk("edge13_released", ar_v[0], 1);
        @(negedge clk);
        chk("edge14_run_cnt", rc_a[0], 1);

        // Halt at run_cnt 37
        wait_rc0(37, 100);
        halt_v[0] = 1'b1;
        @(negedge clk);
        halt_v[0] = 1'b0;
        chk("halt_halted", hl_v[0], 1);
        chk("halt_timeout", to_v[0], 0);
        chk("halt_run_cnt", rc_a[0], 38);

        // Re-reset, then halt pulses in HOLD must be ignored
        pulse_sw0();
        chk("swrst_cpu_rst", cpu_a[0], 3);
        chk("swrst_halted", hl_v[0], 0);
        halt_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        halt_v[0] = 1'b0;
        chk("hold_halt_ignored", hl_v[0], 0);

        // Software reset at run_cnt 120, identical re-release
        wait_rc0(120, 200);
        pulse_sw0();
        chk("sw120_cpu_rst", cpu_a[0], 3);
        chk("sw120_run_cnt", rc_a[0], 0);
        chk("sw120_timeout", to_v[0], 0);
        repeat (10) @(negedge clk);
        chk("re_edge10_cpu_rst", cpu_a[0], 3);
        @(negedge clk);
        chk("re_edge11_cpu_rst", cpu_a[0], 2);
        repeat (2) @(negedge clk);
        chk("re_edge13_cpu_rst", cpu_a[0], 0);

        // Free run to timeout, then frozen
        wait_halt0(300);
        chk("to_run_cnt", rc_a[0], 200);
        chk("to_timeout", to_v[0], 1);
        chk("to_cpu_rst", cpu_a[0], 3);
        repeat (50) @(negedge clk);
        chk("frozen_run_cnt", rc_a[0], 200);
        chk("frozen_timeout", to_v[0], 1);

        // Reset in the middle of RELEASE, 4 domains stagger 3
        pulse_rst(1);
        repeat (9) @(negedge clk);
        chk("u1_bit1_clear", cpu_a[1], 4'b1100);
        pulse_rst(1);
        chk("u1_midrel_reset", cpu_a[1], 4'b1111);
        repeat (6) @(negedge clk);
        chk("u1_rel_bit0", cpu_a[1], 4'b1110);
        repeat (3) @(negedge clk);
        chk("u1_rel_bit1", cpu_a[1], 4'b1100);
        repeat (3) @(negedge clk);
        chk("u1_rel_bit2", cpu_a[1], 4'b1000);
        repeat (3) @(negedge clk);
        chk("u1_rel_bit3", cpu_a[1], 4'b0000);
        chk("u1_released", ar_v[1], 1);

        // Zero stagger: all three domains on one edge
        pulse_rst(2);
        repeat (3) @(negedge clk);
        chk("u2_hold_cpu_rst", cpu_a[2], 3'b111);
        @(negedge clk);
        chk("u2_all_clear", cpu_a[2], 3'b000);
        chk("u2_released", ar_v[2], 1);

        // No timeout, 4-bit counter saturates
        pulse_rst(3);
        repeat (40) @(negedge clk);
        chk("u3_sat_run_cnt", rc_a[3], 15);
        chk("u3_sat_timeout", to_v[3], 0);
        halt_v[3] = 1'b1;
        @(negedge clk);
        halt_v[3] = 1'b0;
        chk("u3_halt_halted", hl_v[3], 1);
        chk("u3_halt_run_cnt", rc_a[3], 15);

        // Randomised traffic on all instances
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 4; k++) begin
                rst_v[k]  = ($urandom_range(0, 199) != 0);
                sw_v[k]   = ($urandom_range(0, 299) == 0);
                halt_v[k] = ($urandom_range(0, 149) == 0);
            end
            @(negedge clk);
        end
        rst_v = 4'hF; sw_v = 4'h0; halt_v = 4'h0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
